// File: rtl/time_pkg.sv
// Shared field widths, limits, set-field codes and CT layout for the time keeper and display stage.
package time_pkg;

    localparam int unsigned DAY_W  = 3;
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MT_W   = 3;
    localparam int unsigned MU_W   = 4;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned CT_W   = DAY_W + HOUR_W + MT_W + MU_W;
    localparam int unsigned ST_W   = CT_W + 1;

    localparam int unsigned DAY_MAX  = 6;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MT_MAX   = 5;
    localparam int unsigned MU_MAX   = 9;
    localparam int unsigned SEC_MAX  = 59;

    // CT bit positions, consumed by the display stage
    localparam int unsigned CT_MU_LO   = 0;
    localparam int unsigned CT_MU_HI   = 3;
    localparam int unsigned CT_MT_LO   = 4;
    localparam int unsigned CT_MT_HI   = 6;
    localparam int unsigned CT_HOUR_LO = 7;
    localparam int unsigned CT_HOUR_HI = 11;
    localparam int unsigned CT_DAY_LO  = 12;
    localparam int unsigned CT_DAY_HI  = 14;

    typedef enum logic [1:0] {
        CW_RUN  = 2'b00,
        CW_MIN  = 2'b01,
        CW_HOUR = 2'b10,
        CW_DAY  = 2'b11
    } cw_e;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    typedef struct packed {
        logic [DAY_W-1:0]  day;
        logic [HOUR_W-1:0] hour;
        logic [MT_W-1:0]   min_tens;
        logic [MU_W-1:0]   min_units;
    } ct_t;

endpackage

// File: rtl/tk_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; carry_c flags an enabled step out of MAX.
module tk_wrap_counter
    import time_pkg::*;
#(
    parameter int unsigned W   = MU_W,
    parameter int unsigned MAX = MU_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         ld0,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt_c,
    output logic         carry_c
);

    logic at_max_c;

    assign at_max_c = (q == W'(MAX));
    assign carry_c  = en && at_max_c;

    // ld0 wins over en so a held field stays at zero
    always_comb begin
        nxt_c = q;
        if (ld0) begin
            nxt_c = '0;
        end else if (en) begin
            nxt_c = at_max_c ? '0 : q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= nxt_c;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Day/hour/minute/second keeper with field-by-field manual setting.
// Optional alarm comparison is enabled by defining ALARM_MATCH_EN.
module time_keeper
    import time_pkg::*;
#(
    parameter int unsigned TICK_DIV = 256,
    parameter int unsigned DIV_W    = 16
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic [1:0]        CW,
    input  logic              Inc,
    input  logic [ST_W-1:0]   ST,
    output logic [CT_W-1:0]   CT,
    output logic [SEC_W-1:0]  Sec,
    output logic              MinTick,
    output logic              Match
);

    mode_e state;
    mode_e state_nxt;
    logic  counting_c;

    logic [DIV_W-1:0] pre;
    logic             sec_tick_c;
    logic             inc_q;
    logic             inc_rise_c;
    logic             set_min_c;
    logic             set_hour_c;
    logic             set_day_c;

    logic sec_carry_c, mu_carry_c, mt_carry_c, hour_carry_c, day_carry_c;
    logic mu_en_c, hour_en_c, day_en_c;

    logic [SEC_W-1:0]  sec_q,  unused_sec_nxt;
    logic [MU_W-1:0]   mu_q,   mu_nxt_c;
    logic [MT_W-1:0]   mt_q,   mt_nxt_c;
    logic [HOUR_W-1:0] hour_q, hour_nxt_c;
    logic [DAY_W-1:0]  day_q,  day_nxt_c;
    ct_t               ct_now;
    ct_t               ct_nxt_c;
    logic              unused_day_carry;

    // Mode register; CW acts in the same cycle so SET beats a coincident sec_tick
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state <= MODE_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = MODE_RUN;
        counting_c = 1'b0;
        if (CW != CW_RUN) begin
            state_nxt = MODE_SET;
        end
        counting_c = (state_nxt == MODE_RUN);
    end

    assign sec_tick_c = counting_c && (pre == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            pre   <= '0;
            inc_q <= 1'b0;
        end else begin
            pre   <= (!counting_c || sec_tick_c) ? '0 : pre + DIV_W'(1);
            inc_q <= Inc;
        end
    end

    // Set increments act on the field selected this cycle, without carry
    assign inc_rise_c = Inc && !inc_q;
    assign set_min_c  = inc_rise_c && (CW == CW_MIN);
    assign set_hour_c = inc_rise_c && (CW == CW_HOUR);
    assign set_day_c  = inc_rise_c && (CW == CW_DAY);

    assign mu_en_c   = sec_carry_c || set_min_c;
    assign hour_en_c = (mt_carry_c && counting_c) || set_hour_c;
    assign day_en_c  = (hour_carry_c && counting_c) || set_day_c;

    tk_wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk(Clk), .rst_n(Clr), .en(sec_tick_c), .ld0(!counting_c),
        .q(sec_q), .nxt_c(unused_sec_nxt), .carry_c(sec_carry_c)
    );

    tk_wrap_counter #(.W(MU_W), .MAX(MU_MAX)) u_min_units (
        .clk(Clk), .rst_n(Clr), .en(mu_en_c), .ld0(1'b0),
        .q(mu_q), .nxt_c(mu_nxt_c), .carry_c(mu_carry_c)
    );

    tk_wrap_counter #(.W(MT_W), .MAX(MT_MAX)) u_min_tens (
        .clk(Clk), .rst_n(Clr), .en(mu_carry_c), .ld0(1'b0),
        .q(mt_q), .nxt_c(mt_nxt_c), .carry_c(mt_carry_c)
    );

    tk_wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk(Clk), .rst_n(Clr), .en(hour_en_c), .ld0(1'b0),
        .q(hour_q), .nxt_c(hour_nxt_c), .carry_c(hour_carry_c)
    );

    tk_wrap_counter #(.W(DAY_W), .MAX(DAY_MAX)) u_day (
        .clk(Clk), .rst_n(Clr), .en(day_en_c), .ld0(1'b0),
        .q(day_q), .nxt_c(day_nxt_c), .carry_c(day_carry_c)
    );

    assign unused_day_carry = day_carry_c;

    assign ct_now   = '{day: day_q, hour: hour_q, min_tens: mt_q, min_units: mu_q};
    assign ct_nxt_c = '{day: day_nxt_c, hour: hour_nxt_c, min_tens: mt_nxt_c, min_units: mu_nxt_c};
    assign CT       = ct_now;
    assign Sec      = sec_q;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            MinTick <= 1'b0;
        end else begin
            MinTick <= mu_en_c;
        end
    end

`ifdef ALARM_MATCH_EN
    logic match_c;

    // Compare against the post-rollover time so the pulse lines up with Sec==0
    assign match_c = counting_c && (state == MODE_RUN) && sec_carry_c && ST[ST_W-1]
                     && (ct_nxt_c == ST[CT_W-1:0]);

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            Match <= 1'b0;
        end else begin
            Match <= match_c;
        end
    end
`else
    logic unused_alarm;

    assign unused_alarm = ^{ST, ct_nxt_c, state};
    assign Match        = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper with TICK_DIV=4; honours ALARM_MATCH_EN when defined.
module tb_time_keeper;

    localparam int TICK = 4;
    localparam int WEEK = 7 * 86400;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic [1:0]  CW  = 2'b00;
    logic        Inc = 1'b0;
    logic [15:0] ST  = 16'h0000;
    logic [14:0] CT;
    logic [5:0]  Sec;
    logic        MinTick;
    logic        Match;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    int m_day = 0, m_hour = 0, m_min = 0, m_sec = 0, m_pre = 0, t = 0;
    bit m_incq = 1'b0, e_mt = 1'b0, e_match = 1'b0;

    time_keeper #(.TICK_DIV(TICK), .DIV_W(16)) dut (
        .Clk(Clk), .Clr(Clr), .CW(CW), .Inc(Inc), .ST(ST),
        .CT(CT), .Sec(Sec), .MinTick(MinTick), .Match(Match)
    );

    initial forever #5 Clk = ~Clk;

    function automatic logic [14:0] ct_of(input int d, input int h, input int m);
        return {3'(d), 5'(h), 3'(m / 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-week second count for running, field arithmetic for setting
    initial forever begin
        @(posedge Clk or negedge Clr);
        if (!Clr) begin
            m_day = 0; m_hour = 0; m_min = 0; m_sec = 0; m_pre = 0;
            m_incq = 1'b0; e_mt = 1'b0; e_match = 1'b0;
        end else begin
            e_mt = 1'b0;
            e_match = 1'b0;
            if (CW == 2'b00) begin
                if (m_pre == TICK - 1) begin
                    m_pre = 0;
                    t = (((m_day * 24 + m_hour) * 60 + m_min) * 60 + m_sec + 1) % WEEK;
                    m_sec  = t % 60;
                    m_min  = (t / 60) % 60;
                    m_hour = (t / 3600) % 24;
                    m_day  = t / 86400;
                    if (m_sec == 0) begin
                        e_mt = 1'b1;
`ifdef ALARM_MATCH_EN
                        if (ST[15] && ct_of(m_day, m_hour, m_min) == ST[14:0]) e_match = 1'b1;
`endif
                    end
                end else begin
                    m_pre++;
                end
            end else begin
                m_pre = 0;
                m_sec = 0;
                if (Inc && !m_incq) begin
                    case (CW)
                        2'b01: begin m_min = (m_min + 1) % 60; e_mt = 1'b1; end
                        2'b10: m_hour = (m_hour + 1) % 24;
                        default: m_day = (m_day + 1) % 7;
                    endcase
                end
            end
            m_incq = Inc;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge Clk);
        if (checking) begin
            chk("ct",      32'(CT),      32'(ct_of(m_day, m_hour, m_min)));
            chk("sec",     32'(Sec),     32'(m_sec));
            chk("mintick", 32'(MinTick), 32'(e_mt));
            chk("match",   32'(Match),   32'(e_match));
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Clr = 1'b0; CW = 2'b00; Inc = 1'b0;
        @(negedge Clk);
        Clr = 1'b1;
    endtask

    task automatic set_field(input logic [1:0] cw, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            CW = cw; Inc = 1'b1;
            @(negedge Clk);
            Inc = 1'b0;
        end
    endtask

    task automatic alarm_run(input logic [15:0] st_word);
        do_reset();
        ST = st_word;
        set_field(2'b11, 2);
        set_field(2'b10, 7);
        set_field(2'b01, 29);
        CW = 2'b00;
        run(240);
        chk("alarm_ct", 32'(CT), 32'h23B0);
    endtask

    initial begin
        #2 Clr = 1'b0;
        #1 checking = 1'b1;
        run(2);
        chk("reset_ct",  32'(CT),  32'h0);
        chk("reset_sec", 32'(Sec), 32'h0);

        // Reset timing and mid-count async clear
        do_reset();
        set_field(2'b01, 2);
        CW = 2'b00;
        run(3);
        chk("sec_pre_tick", 32'(Sec), 32'd0);
        run(1);
        chk("sec_first_tick", 32'(Sec), 32'd1);
        run(6);
        chk("ct_before_clr", 32'(CT), 32'h0002);
        Clr = 1'b0;
        #1;
        chk("clr_ct",  32'(CT),      32'h0);
        chk("clr_sec", 32'(Sec),     32'h0);
        chk("clr_mt",  32'(MinTick), 32'h0);
        @(negedge Clk);
        Clr = 1'b1;
        run(3);
        chk("release_sec0", 32'(Sec), 32'd0);
        run(1);
        chk("release_sec1", 32'(Sec), 32'd1);

        // Full week wrap
        do_reset();
        set_field(2'b11, 6);
        set_field(2'b10, 23);
        set_field(2'b01, 59);
        CW = 2'b00;
        run(239);
        chk("wrap_pre_ct",  32'(CT),  32'h6BD9);
        chk("wrap_pre_sec", 32'(Sec), 32'd59);
        run(1);
        chk("wrap_ct",  32'(CT),      32'h0000);
        chk("wrap_sec", 32'(Sec),     32'd0);
        chk("wrap_mt",  32'(MinTick), 32'd1);
        run(1);
        chk("wrap_mt_off", 32'(MinTick), 32'd0);

        // BCD carries
        do_reset();
        set_field(2'b01, 9);
        CW = 2'b00;
        run(239);
        chk("bcd9_pre", 32'(CT), 32'h0009);
        run(1);
        chk("bcd_units_carry", 32'(CT), 32'h0010);
        do_reset();
        set_field(2'b01, 59);
        CW = 2'b00;
        run(240);
        chk("bcd_hour_carry", 32'(CT), 32'h0080);

        // Field setting
        do_reset();
        set_field(2'b01, 58);
        chk("set_min58", 32'(CT), 32'h0058);
        set_field(2'b01, 3);
        chk("set_min_wrap", 32'(CT), 32'h0001);
        set_field(2'b11, 3);
        set_field(2'b10, 23);
        chk("set_hour23", 32'(CT), 32'h3B81);
        set_field(2'b10, 1);
        chk("set_hour_wrap", 32'(CT), 32'h3001);
        @(negedge Clk);
        CW = 2'b01; Inc = 1'b1;
        repeat (20) @(negedge Clk);
        Inc = 1'b0;
        @(negedge Clk);
        chk("inc_held", 32'(CT),  32'h3002);
        chk("set_sec0", 32'(Sec), 32'd0);

        // SET beats a coincident tick; restart from zero on return to RUN
        do_reset();
        run(3);
        @(negedge Clk);
        CW = 2'b01;
        run(1);
        chk("prio_sec", 32'(Sec), 32'd0);
        run(3);
        @(negedge Clk);
        CW = 2'b00;
        run(3);
        chk("restart_sec0", 32'(Sec), 32'd0);
        run(1);
        chk("restart_sec1", 32'(Sec), 32'd1);

        // Alarm enabled word, then disabled word
        alarm_run(16'hA3B0);
`ifdef ALARM_MATCH_EN
        chk("alarm_hit", 32'(Match), 32'd1);
`else
        chk("alarm_tied", 32'(Match), 32'd0);
`endif
        run(1);
        chk("alarm_one_cycle", 32'(Match), 32'd0);
        alarm_run(16'h23B0);
        chk("alarm_disabled", 32'(Match), 32'd0);

        run(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
